// File: rtl/ibutterfly_2_serial.sv
// Serial 2-point inverse butterfly: takes X0, X1 one per handshake, returns (X0+X1)/2 and (X0-X1)/2.
// Define IBFLY_ROUND_EN for round-half-up with saturation; otherwise results truncate toward -inf.
module ibutterfly_2_serial #(
    parameter  int N = 4,
    localparam int W = 2**N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_idx
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GET0 = 3'd1,
        GET1 = 3'd2,
        PUT0 = 3'd3,
        PUT1 = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic         r_in_ready;
    logic         r_out_valid;
    logic [W-1:0] r_out_re;
    logic [W-1:0] r_out_im;
    logic         r_out_idx;
    logic [W-1:0] r_x0_re;
    logic [W-1:0] r_x0_im;
    logic [W-1:0] r_y1_re;
    logic [W-1:0] r_y1_im;

    logic w_in_xfer;
    logic w_out_xfer;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // Lane 0 is the real part, lane 1 the imaginary part; both use identical arithmetic.
    logic [W-1:0] w_a   [2];
    logic [W-1:0] w_b   [2];
    logic [W-1:0] w_y0  [2];
    logic [W-1:0] w_y1  [2];

    assign w_a[0] = r_x0_re;
    assign w_a[1] = r_x0_im;
    assign w_b[0] = in_re;
    assign w_b[1] = in_im;

`ifdef IBFLY_ROUND_EN
    // Extra headroom bit keeps the +1 on the largest difference from wrapping before the shift.
    function automatic logic [W-1:0] halve(input logic [W:0] s);
        logic [W+1:0] p;
        logic [W:0]   q;
        p = {s[W], s} + {{(W+1){1'b0}}, 1'b1};
        q = p[W+1:1];
        if (!q[W] && q[W-1])
            halve = {1'b0, {(W-1){1'b1}}};
        else
            halve = q[W-1:0];
    endfunction
`else
    function automatic logic [W-1:0] halve(input logic [W:0] s);
        halve = s[W:1];
    endfunction
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [W:0] w_sum;
            logic [W:0] w_dif;
            assign w_sum    = {w_a[gi][W-1], w_a[gi]} + {w_b[gi][W-1], w_b[gi]};
            assign w_dif    = {w_a[gi][W-1], w_a[gi]} - {w_b[gi][W-1], w_b[gi]};
            assign w_y0[gi] = halve(w_sum);
            assign w_y1[gi] = halve(w_dif);
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = GET0;
            GET0:    if (w_in_xfer)  w_state_next = GET1;
            GET1:    if (w_in_xfer)  w_state_next = PUT0;
            PUT0:    if (w_out_xfer) w_state_next = PUT1;
            PUT1:    if (w_out_xfer) w_state_next = GET0;
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they never depend on this cycle's inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == GET0) || (w_state_next == GET1);
            r_out_valid <= (w_state_next == PUT0) || (w_state_next == PUT1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0_re   <= '0;
            r_x0_im   <= '0;
            r_y1_re   <= '0;
            r_y1_im   <= '0;
            r_out_re  <= '0;
            r_out_im  <= '0;
            r_out_idx <= 1'b0;
        end else begin
            if (w_in_xfer && r_state == GET0) begin
                r_x0_re <= in_re;
                r_x0_im <= in_im;
            end
            if (w_in_xfer && r_state == GET1) begin
                r_out_re  <= w_y0[0];
                r_out_im  <= w_y0[1];
                r_out_idx <= 1'b0;
                r_y1_re   <= w_y1[0];
                r_y1_im   <= w_y1[1];
            end
            if (w_out_xfer && r_state == PUT0) begin
                r_out_re  <= r_y1_re;
                r_out_im  <= r_y1_im;
                r_out_idx <= 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_idx   = r_out_idx;

endmodule

// File: tb/tb_ibutterfly_2_serial.sv
// Directed bench for ibutterfly_2_serial (W=16); expected values follow IBFLY_ROUND_EN if defined.
module tb_ibutterfly_2_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        out_idx;

    int tests;
    int fails;

    ibutterfly_2_serial #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one input sample and return 1ns after the edge that transfers it.
    task automatic send(input int re, input int im);
        int n;
        in_valid = 1'b1;
        in_re    = 16'(re);
        in_im    = 16'(im);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("[TB] in  re=%0d im=%0d", re, im);
    endtask

    // Accept one output sample, checking it before the transferring edge.
    task automatic recv(input int re, input int im, input int idx);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("recv_out_valid", int'(out_valid), 1);
        check("recv_re",  int'($signed(out_re)), re);
        check("recv_im",  int'($signed(out_im)), im);
        check("recv_idx", int'(out_idx), idx);
        $display("[TB] out re=%0d im=%0d idx=%0d", $signed(out_re), $signed(out_im), out_idx);
        @(posedge clk); #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_re     = '0;
        in_im     = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_re",    int'(out_re), 0);
        check("rst_out_im",    int'(out_im), 0);
        check("rst_out_idx",   int'(out_idx), 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("first_in_ready",  int'(in_ready), 1);
        check("first_out_valid", int'(out_valid), 0);

        // Basic pair
        out_ready = 1'b1;
        send(100, 20);
        send(40, -10);
        check("lat_out_valid", int'(out_valid), 1);
        check("lat_in_ready",  int'(in_ready), 0);
        recv(70, 5, 0);
        recv(30, 15, 1);
        check("basic_in_ready_after", int'(in_ready), 1);
        check("basic_out_valid_after", int'(out_valid), 0);

        // Odd and negative sums
        send(3, -3);
        send(0, 0);
`ifdef IBFLY_ROUND_EN
        recv(2, -1, 0);
        recv(2, -1, 1);
`else
        recv(1, -2, 0);
        recv(1, -2, 1);
`endif

        // Extremes
        send(32767, -32768);
        send(-32768, -32768);
`ifdef IBFLY_ROUND_EN
        recv(0, -32768, 0);
        recv(32767, 0, 1);
`else
        recv(-1, -32768, 0);
        recv(32767, 0, 1);
`endif

        // Backpressure in PUT0
        out_ready = 1'b0;
        send(1000, -200);
        send(10, 50);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_re",    int'($signed(out_re)), 505);
            check("bp_out_im",    int'($signed(out_im)), -75);
            check("bp_out_idx",   int'(out_idx), 0);
            check("bp_in_ready",  int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_x1_idx", int'(out_idx), 1);
        check("bp_x1_re",  int'($signed(out_re)), 495);
        check("bp_x1_im",  int'($signed(out_im)), -125);
        @(posedge clk); #1;
        check("bp_in_ready_after", int'(in_ready), 1);

        // Input ignored during PUT0/PUT1
        send(6, 4);
        send(2, -4);
        in_valid  = 1'b1;
        in_re     = 16'h7FFF;
        in_im     = 16'h7FFF;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ign_in_ready", int'(in_ready), 0);
        recv(4, 0, 0);
        recv(2, 4, 1);
        in_valid = 1'b0;
        send(10, 10);
        send(4, -2);
        recv(7, 4, 0);
        recv(3, 6, 1);

        // Reset mid-operation after X0 transfer
        send(500, 0);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  int'(in_ready), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #5 rst = 1'b0;
        send(8, 8);
        send(2, 2);
        recv(5, 5, 0);
        recv(3, 3, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
